// File: rtl/lfsr_pkg.sv
// Shared types, constants and tap rule for the 4-bit burst LFSR scheduler.
package lfsr_pkg;

    localparam int                LFSR_W    = 4;
    localparam logic [LFSR_W-1:0] SAFE_SEED = 4'h9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Fibonacci step: new MSB from taps 1 and 0, remaining bits shift down.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] ff);
        return {ff[1] ^ ff[0], ff[3:1]};
    endfunction

    // The all-zero state locks up the LFSR, so it is never loaded.
    function automatic logic [LFSR_W-1:0] fix_seed(input logic [LFSR_W-1:0] seed);
        return (seed == '0) ? SAFE_SEED : seed;
    endfunction

endpackage

// File: rtl/lfsr4_core.sv
// 4-bit LFSR register: synchronous seed load (wins over step), step enable,
// asynchronous reset to the safe seed.
module lfsr4_core
    import lfsr_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_step,
    output logic [LFSR_W-1:0] o_state
);

    logic [LFSR_W-1:0] r_ff;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ff <= SAFE_SEED;
        end else if (i_load) begin
            r_ff <= fix_seed(i_seed);
        end else if (i_step) begin
            r_ff <= lfsr_next(r_ff);
        end
    end

    assign o_state = r_ff;

endmodule

// File: rtl/lfsr_burst_sched.sv
// Round-robin scheduler granting one of two requesters a seeded LFSR burst
// of programmable length over a valid/ready stream.
module lfsr_burst_sched
    import lfsr_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_req,
    input  logic [LFSR_W-1:0] i_seed0,
    input  logic [LFSR_W-1:0] i_seed1,
    input  logic [CNT_W-1:0]  i_len0,
    input  logic [CNT_W-1:0]  i_len1,
    input  logic              i_ready,
    output logic [1:0]        o_gnt,
    output logic              o_busy,
    output logic              o_valid,
    output logic [LFSR_W-1:0] o_data,
    output logic              o_done
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_gnt;
    logic [CNT_W:0]    r_cnt;
    logic              r_last;
    logic [1:0]        w_pick;
    logic [LFSR_W-1:0] w_seed_sel;
    logic [CNT_W-1:0]  w_len_sel;
    logic [CNT_W:0]    w_cnt_load;
    logic              w_load;
    logic              w_step;
    logic [LFSR_W-1:0] w_lfsr;

    // r_last holds the index granted most recently; reset value 1 favours requester 0.
    always_comb begin
        w_pick = 2'b00;
        case (i_req)
            2'b01:   w_pick = 2'b01;
            2'b10:   w_pick = 2'b10;
            2'b11:   w_pick = r_last ? 2'b01 : 2'b10;
            default: w_pick = 2'b00;
        endcase
    end

    assign w_seed_sel = w_pick[1] ? i_seed1 : i_seed0;
    assign w_len_sel  = w_pick[1] ? i_len1  : i_len0;
    assign w_cnt_load = (w_len_sel == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, w_len_sel};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (|i_req) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (i_ready) begin
                    w_step = 1'b1;
                    if (r_cnt == (CNT_W+1)'(1)) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gnt  <= 2'b00;
            r_cnt  <= '0;
            r_last <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_gnt <= w_pick;
                        r_cnt <= w_cnt_load;
                    end
                end
                RUN: begin
                    if (w_step) begin
                        r_cnt <= r_cnt - (CNT_W+1)'(1);
                    end
                end
                DONE: begin
                    r_last <= r_gnt[1];
                    r_gnt  <= 2'b00;
                end
                default: begin
                    r_gnt <= 2'b00;
                end
            endcase
        end
    end

    lfsr4_core u_lfsr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_load),
        .i_seed  (w_seed_sel),
        .i_step  (w_step),
        .o_state (w_lfsr)
    );

    assign o_gnt   = r_gnt;
    assign o_busy  = (r_state != IDLE);
    assign o_valid = (r_state == RUN);
    assign o_data  = (r_state == RUN) ? w_lfsr : '0;
    assign o_done  = (r_state == DONE);

endmodule

// File: tb/tb_lfsr_burst_sched.sv
// Directed bench for lfsr_burst_sched: single burst, contention, backpressure,
// zero seed/length edge case and asynchronous reset mid-burst.
module tb_lfsr_burst_sched;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [3:0] seed0, seed1;
    logic [3:0] len0, len1;
    logic       ready;
    logic [1:0] gnt;
    logic       busy, valid, done;
    logic [3:0] data;

    int n_checks = 0;
    int n_errors = 0;

    // Full period from seed 9, hand-stepped with nxt = {f1^f0, f[3:1]}.
    logic [3:0] seq9 [16] = '{4'h9, 4'hC, 4'h6, 4'hB, 4'h5, 4'hA, 4'hD, 4'hE,
                              4'hF, 4'h7, 4'h3, 4'h1, 4'h8, 4'h4, 4'h2, 4'h9};

    lfsr_burst_sched #(.CNT_W(4)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req),
        .i_seed0 (seed0),
        .i_seed1 (seed1),
        .i_len0  (len0),
        .i_len1  (len1),
        .i_ready (ready),
        .o_gnt   (gnt),
        .o_busy  (busy),
        .o_valid (valid),
        .o_data  (data),
        .o_done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [3:0] exp_data, input logic [1:0] exp_gnt);
        chk({tag, ".valid"}, 32'(valid), 32'd1);
        chk({tag, ".data"},  32'(data),  32'(exp_data));
        chk({tag, ".gnt"},   32'(gnt),   32'(exp_gnt));
        chk({tag, ".done"},  32'(done),  32'd0);
    endtask

    task automatic chk_done(input string tag, input logic [1:0] exp_gnt);
        chk({tag, ".done"},  32'(done),  32'd1);
        chk({tag, ".valid"}, 32'(valid), 32'd0);
        chk({tag, ".busy"},  32'(busy),  32'd1);
        chk({tag, ".gnt"},   32'(gnt),   32'(exp_gnt));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".gnt"},   32'(gnt),   32'd0);
        chk({tag, ".busy"},  32'(busy),  32'd0);
        chk({tag, ".valid"}, 32'(valid), 32'd0);
        chk({tag, ".data"},  32'(data),  32'd0);
        chk({tag, ".done"},  32'(done),  32'd0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        req   = 2'b00;
        seed0 = 4'h0;
        seed1 = 4'h0;
        len0  = 4'h0;
        len1  = 4'h0;
        ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk_idle("rst");
        rst = 1'b0;

        // Single burst: 9, C, 6, B then done
        seed0 = 4'h9; len0 = 4'd4; req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk_word($sformatf("single.w%0d", i), seq9[i], 2'b01);
        end
        @(negedge clk);
        chk_done("single.done", 2'b01);
        @(negedge clk);
        chk_idle("single.idle");

        // Contention from reset: grants 01, 10, 01
        reset_pulse();
        seed0 = 4'h9; seed1 = 4'h5; len0 = 4'd2; len1 = 4'd2; req = 2'b11;
        @(negedge clk); chk_word("cont.a0", 4'h9, 2'b01);
        @(negedge clk); chk_word("cont.a1", 4'hC, 2'b01);
        @(negedge clk); chk_done("cont.adone", 2'b01);
        @(negedge clk); chk_idle("cont.aidle");
        @(negedge clk); chk_word("cont.b0", 4'h5, 2'b10);
        @(negedge clk); chk_word("cont.b1", 4'hA, 2'b10);
        @(negedge clk); chk_done("cont.bdone", 2'b10);
        @(negedge clk); chk_idle("cont.bidle");
        @(negedge clk); chk_word("cont.c0", 4'h9, 2'b01);
        req = 2'b00;
        @(negedge clk); chk_word("cont.c1", 4'hC, 2'b01);
        @(negedge clk); chk_done("cont.cdone", 2'b01);
        @(negedge clk); chk_idle("cont.cidle");

        // Backpressure: ready low for three cycles after the first word
        seed0 = 4'h9; len0 = 4'd3; req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        chk_word("bp.w0", 4'h9, 2'b01);
        ready = 1'b0;
        seed0 = 4'h3; len0 = 4'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_word($sformatf("bp.hold%0d", i), 4'h9, 2'b01);
        end
        ready = 1'b1;
        @(negedge clk); chk_word("bp.w1", 4'hC, 2'b01);
        @(negedge clk); chk_word("bp.w2", 4'h6, 2'b01);
        @(negedge clk); chk_done("bp.done", 2'b01);
        @(negedge clk); chk_idle("bp.idle");

        // Zero seed and zero length: 16 words, wraps back to 9
        seed0 = 4'h0; len0 = 4'h0; req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            chk_word($sformatf("edge.w%0d", i), seq9[i], 2'b01);
        end
        @(negedge clk); chk_done("edge.done", 2'b01);
        @(negedge clk); chk_idle("edge.idle");

        // Asynchronous reset mid-RUN, req dropped a cycle earlier
        seed0 = 4'h9; len0 = 4'd5; req = 2'b01;
        @(negedge clk);
        chk_word("arst.w0", 4'h9, 2'b01);
        req = 2'b00;
        @(negedge clk);
        chk_word("arst.w1", 4'hC, 2'b01);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("arst.async");
        @(negedge clk);
        chk_idle("arst.held");
        rst = 1'b0;
        seed1 = 4'h6; len1 = 4'd1; req = 2'b10;
        @(negedge clk);
        req = 2'b00;
        chk_word("arst.r1", 4'h6, 2'b10);
        @(negedge clk); chk_done("arst.done", 2'b10);
        @(negedge clk); chk_idle("arst.idle");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lfsr_burst_sched.md
# lfsr_burst_sched

Round-robin scheduler that shares one 4-bit Fibonacci LFSR between two requesters. Each granted requester supplies a seed and a burst length; the block loads the LFSR and streams that many pseudo-random words over a valid/ready interface, then signals done and re-arbitrates. It sits between the test-pattern and scrambler clients and the shared LFSR datapath.

## Interface
- CNT_W, 4, width of each burst-length input; a length of 0 means 2^CNT_W words.
- Clk  in  1  clock, all state updates on rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- req  in  2  request lines; bit i belongs to requester i.
- seed0  in  4  seed for requester 0, sampled at grant.
- seed1  in  4  seed for requester 1, sampled at grant.
- len0  in  CNT_W  burst length for requester 0, sampled at grant.
- len1  in  CNT_W  burst length for requester 1, sampled at grant.
- ready  in  1  consumer accepts the current word.
- gnt  out  2  one-hot grant, held for the whole burst, including the DONE cycle.
- busy  out  1  high in RUN and DONE.
- valid  out  1  data word present.
- data  out  4  LFSR state while valid, 4'h0 otherwise.
- done  out  1  one-cycle pulse after the last accepted word.

## Operation
- LFSR step: nxt[3] = ff[1]^ff[0]; nxt[2:0] = ff[3:1]. Period 15 over the non-zero states. State 0 is illegal.
- Seed rule: a sampled seed of 4'h0 is replaced by 4'h9.
- FSM states: IDLE, RUN, DONE.
- IDLE
  - If req is non-zero, arbitrate round-robin. The requester not granted last has priority; after reset, requester 0 has priority.
  - Register gnt, load the LFSR with the (fixed-up) seed and load the counter with the length, then go to RUN.
  - Counter is CNT_W+1 bits wide; a length of 0 loads 2^CNT_W.
- RUN
  - valid = 1 and data = LFSR state.
  - On valid && ready, the LFSR steps and the counter decrements.
  - If the counter was 1 at that handshake, go to DONE.
  - Without ready, data and counter hold.
- DONE
  - done = 1 and valid = 0.
  - Update the last-granted pointer to the current grantee.
  - Go to IDLE; gnt clears on entry to IDLE.
- req is sampled only in IDLE. Dropping req mid-burst does not abort the burst. seed and len changes after grant are ignored.
- Reset mid-operation aborts the burst immediately and returns to IDLE with the pointer reset.
- Reset values:
  - state = IDLE
  - gnt = 2'b00, busy = 0, valid = 0, data = 4'h0, done = 0
  - LFSR = 4'h9, counter = 0
  - priority = requester 0

## Timing
- Grant latency: req is sampled at edge T; gnt, busy, valid and the first word (the seed) are visible after T.
- Throughput: one word per cycle with ready held high.
- Burst of N words with ready high: N RUN cycles, then 1 DONE cycle, then 1 IDLE cycle before the next grant can appear.
- With both requesters continuously requesting, grants alternate 01, 10, 01, …
- Simultaneous new requests from both requesters in IDLE are resolved by the pointer only; there is no other tie-break.
- All outputs are registered or decoded directly from registered state; there are no combinational paths from ready or req to outputs.

## Structure
- Package lfsr_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - LFSR_W = 4;
  - SAFE_SEED = 4'h9;
  - the lfsr_next function implementing the tap rule.
- Sub-module lfsr4_core: the 4-bit register with a synchronous load (seed), an enable (step) and asynchronous reset to SAFE_SEED.
- Arbitration, counter and FSM live in lfsr_burst_sched.

## Test plan
- Single burst: req = 01, seed0 = 9, len0 = 4, ready = 1.
  - data is 9, C, 6, B on consecutive cycles.
  - done pulses on the next cycle.
  - gnt = 01 from the first word through done.
- Contention: req = 11 held after reset, len = 2 each, seed0 = 9, seed1 = 5.
  - Grant order is 01, 10, 01.
  - The requester-1 burst outputs 5, A.
- Backpressure: seed 9, len 3, ready low for 3 cycles after the first valid.
  - data holds at 9 while ready is low.
  - The sequence then continues C, 6 with no skipped or repeated words.
- Edge values: seed0 = 0, len0 = 0.
  - The first word is 9.
  - Exactly 16 words are produced and the 16th is 9 (wraps after period 15).
  - done follows the 16th handshake.
- Reset and req drop: assert Rst asynchronously mid-RUN, with req dropped one cycle before.
  - Outputs go to their reset values immediately, without waiting for a clock edge.
  - After Rst releases, req = 10 is granted as 10 with seed1 as the first word.
